// File: rtl/hci_package.sv
// Shared HCI constants plus the core/memory bridge response type.
package hci_package;

    localparam int unsigned DEFAULT_DW               = 32;
    localparam int unsigned DEFAULT_AW               = 32;
    localparam int unsigned DEFAULT_BW               = 8;
    localparam int unsigned DEFAULT_IW               = 8;
    localparam int unsigned HCI_BRIDGE_DEFAULT_DEPTH = 2;

    typedef struct packed {
        logic [DEFAULT_DW-1:0] data;
        logic [DEFAULT_IW-1:0] id;
        logic                  opc;
    } hci_bridge_resp_t;

    // Width able to hold fifo occupancy plus one in-flight response.
    function automatic int unsigned hci_bridge_used_width(input int unsigned depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/hci_core_intf.sv
// Core-side HCI port: request channel plus r_valid/r_data response under lrdy.
interface hci_core_intf #(
    parameter int unsigned DW = hci_package::DEFAULT_DW,
    parameter int unsigned AW = hci_package::DEFAULT_AW,
    parameter int unsigned BW = hci_package::DEFAULT_BW
) ();
    logic             req;
    logic             gnt;
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW-1:0]    data;
    logic [DW/BW-1:0] be;
    logic [1:0]       boffs;
    logic             lrdy;
    logic [DW-1:0]    r_data;
    logic             r_valid;
    logic             r_opc;

    modport master (output req, add, wen, data, be, boffs, lrdy,
                    input  gnt, r_data, r_valid, r_opc);
    modport slave  (input  req, add, wen, data, be, boffs, lrdy,
                    output gnt, r_data, r_valid, r_opc);
endinterface

// File: rtl/hci_mem_intf.sv
// Bank-side HCI port: request channel with ID, fixed one-cycle read response.
interface hci_mem_intf #(
    parameter int unsigned DW = hci_package::DEFAULT_DW,
    parameter int unsigned AW = hci_package::DEFAULT_AW,
    parameter int unsigned BW = hci_package::DEFAULT_BW,
    parameter int unsigned IW = hci_package::DEFAULT_IW
) ();
    logic             req;
    logic             gnt;
    logic [AW-1:0]    add;
    logic             wen;
    logic [DW-1:0]    data;
    logic [DW/BW-1:0] be;
    logic [IW-1:0]    id;
    logic [DW-1:0]    r_data;
    logic [IW-1:0]    r_id;

    modport master (output req, add, wen, data, be, id,
                    input  gnt, r_data, r_id);
    modport slave  (input  req, add, wen, data, be, id,
                    output gnt, r_data, r_id);
endinterface

// File: rtl/hci_bridge_resp_fifo.sv
// Register FIFO with synchronous clear; head output reads zero while empty.
module hci_bridge_resp_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned CW    = $clog2(DEPTH + 1),
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/hci_core_mem_bridge.sv
// HCI core-to-bank bridge: credit-gated loads with rolling IDs, buffered responses.
// Optional HCI_BRIDGE_ID_CHECK_EN flags returned IDs that differ from the issued ones via r_opc.
module hci_core_mem_bridge
    import hci_package::*;
#(
    parameter int unsigned DW    = DEFAULT_DW,
    parameter int unsigned AW    = DEFAULT_AW,
    parameter int unsigned BW    = DEFAULT_BW,
    parameter int unsigned IW    = 8,
    parameter int unsigned DEPTH = HCI_BRIDGE_DEFAULT_DEPTH
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    hci_core_intf.slave tcdm_target,
    hci_mem_intf.master tcdm_initiator
);

    localparam int unsigned UW = hci_bridge_used_width(DEPTH);
    localparam int unsigned FW = DW + IW + 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic          inflight_q, inflight_d;
    logic [IW-1:0] id_q, id_d;
    logic [CW-1:0] fifo_cnt;
    logic [UW-1:0] used;
    logic          credit, load_hs, pop;
    logic          fifo_full, fifo_empty;
    logic [FW-1:0] push_data, head;
    logic          resp_opc;
    logic          unused_in;

    // Occupancy is registered, so a pop only frees credit on the following cycle.
    assign used    = UW'(fifo_cnt) + UW'(inflight_q);
    assign credit  = used < UW'(DEPTH);
    assign load_hs = tcdm_initiator.req & tcdm_initiator.gnt & tcdm_target.wen;

    assign tcdm_initiator.req  = tcdm_target.req & (~tcdm_target.wen | credit);
    assign tcdm_target.gnt     = tcdm_initiator.gnt & (~tcdm_target.wen | credit);
    assign tcdm_initiator.add  = tcdm_target.add;
    assign tcdm_initiator.wen  = tcdm_target.wen;
    assign tcdm_initiator.data = tcdm_target.data;
    assign tcdm_initiator.be   = tcdm_target.be;
    assign tcdm_initiator.id   = id_q;

    always_comb begin
        inflight_d = load_hs;
        id_d       = load_hs ? id_q + IW'(1) : id_q;
        if (clear_i) begin
            inflight_d = 1'b0;
            id_d       = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_q <= 1'b0;
            id_q       <= '0;
        end else begin
            inflight_q <= inflight_d;
            id_q       <= id_d;
        end
    end

`ifdef HCI_BRIDGE_ID_CHECK_EN
    logic [IW-1:0]              exp_id;
    logic                       exp_full, exp_empty;
    logic [$clog2(DEPTH+2)-1:0] exp_cnt;
    logic                       unused_exp;

    hci_bridge_resp_fifo #(
        .WIDTH (IW),
        .DEPTH (DEPTH + 1)
    ) i_exp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (load_hs),
        .data_i  (id_q),
        .pop_i   (inflight_q),
        .data_o  (exp_id),
        .full_o  (exp_full),
        .empty_o (exp_empty),
        .count_o (exp_cnt)
    );

    assign resp_opc   = inflight_q & (tcdm_initiator.r_id != exp_id);
    assign unused_exp = ^{exp_full, exp_empty, exp_cnt};
`else
    assign resp_opc = 1'b0;
`endif

    assign push_data = {tcdm_initiator.r_data, tcdm_initiator.r_id, resp_opc};
    assign pop       = ~fifo_empty & tcdm_target.lrdy;

    hci_bridge_resp_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) i_resp_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear_i (clear_i),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign tcdm_target.r_valid = ~fifo_empty;
    assign tcdm_target.r_data  = head[FW-1 -: DW];
    assign tcdm_target.r_opc   = head[0];

    assign unused_in = ^{tcdm_target.boffs, tcdm_initiator.r_id, fifo_full, head[IW:1]};

endmodule
